// File: rtl/amoa_param_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amoa_param_pipe                                                            |
// | Pipelined N-operand adder tree with per-sample exact / lower-OR mode.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amoa_param_pipe #(
   parameter int N_OPS    = 8,
   parameter int W        = 8,
   parameter int APX_BITS = 2,
   parameter int SW       = W + $clog2(N_OPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 apx_en,
   input  logic [N_OPS*W-1:0]   x_flat,
   output logic [SW-1:0]        summ,
   output logic                 out_valid,
   output logic                 out_apx
);
   localparam int L   = $clog2(N_OPS);
   localparam int NP  = 1 << L;
   localparam int UW  = W - APX_BITS;
   localparam int UWS = UW + L;

   logic [N_OPS*W-1:0] x_q;
   logic [L:0]         vld_q;
   logic [L:0]         apx_q;

   // Mode bits and tree levels only advance with their own sample, so gaps hold the last result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         vld_q <= '0;
         apx_q <= '0;
      end else begin
         vld_q <= {vld_q[L-1:0], in_valid};
         if (in_valid) begin
            x_q      <= x_flat;
            apx_q[0] <= apx_en;
         end
         for (int k = 1; k <= L; k++) begin
            if (vld_q[k-1]) apx_q[k] <= apx_q[k-1];
         end
      end
   end

   logic [NP*UWS-1:0] w_leaf_up;
   for (genvar n = 0; n < NP; n++) begin : g_up_leaf
      if (n < N_OPS) begin : g_op
         assign w_leaf_up[n*UWS +: UWS] = UWS'(x_q[n*W + APX_BITS +: UW]);
      end else begin : g_pad
         assign w_leaf_up[n*UWS +: UWS] = '0;
      end
   end

   for (genvar k = 1; k <= L; k++) begin : g_up_lvl
      localparam int NN = NP >> k;
      logic [2*NN*UWS-1:0] w_src;
      logic [NN*UWS-1:0]   up_d;
      logic [NN*UWS-1:0]   up_q;
      if (k == 1) begin : g_first
         assign w_src = w_leaf_up;
      end else begin : g_next
         assign w_src = g_up_lvl[k-1].up_q;
      end
      for (genvar n = 0; n < NN; n++) begin : g_node
         assign up_d[n*UWS +: UWS] = w_src[2*n*UWS +: UWS] + w_src[(2*n+1)*UWS +: UWS];
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst)              up_q <= '0;
         else if (vld_q[k-1])  up_q <= up_d;
      end
   end

   logic [UWS-1:0] w_up;
   assign w_up = g_up_lvl[L].up_q;

   if (APX_BITS > 0) begin : g_low
      localparam int LWS = APX_BITS + L;
      logic [NP*LWS-1:0]      w_leaf_lo;
      logic [NP*APX_BITS-1:0] w_leaf_or;

      for (genvar n = 0; n < NP; n++) begin : g_lo_leaf
         if (n < N_OPS) begin : g_op
            assign w_leaf_lo[n*LWS +: LWS]           = LWS'(x_q[n*W +: APX_BITS]);
            assign w_leaf_or[n*APX_BITS +: APX_BITS] = x_q[n*W +: APX_BITS];
         end else begin : g_pad
            assign w_leaf_lo[n*LWS +: LWS]           = '0;
            assign w_leaf_or[n*APX_BITS +: APX_BITS] = '0;
         end
      end

      // Low lane keeps the exact low sum alongside the OR so either mode can be chosen at the end.
      for (genvar k = 1; k <= L; k++) begin : g_lo_lvl
         localparam int NN = NP >> k;
         logic [2*NN*LWS-1:0]      w_src_lo;
         logic [2*NN*APX_BITS-1:0] w_src_or;
         logic [NN*LWS-1:0]        lo_d, lo_q;
         logic [NN*APX_BITS-1:0]   or_d, or_q;
         if (k == 1) begin : g_first
            assign w_src_lo = w_leaf_lo;
            assign w_src_or = w_leaf_or;
         end else begin : g_next
            assign w_src_lo = g_lo_lvl[k-1].lo_q;
            assign w_src_or = g_lo_lvl[k-1].or_q;
         end
         for (genvar n = 0; n < NN; n++) begin : g_node
            assign lo_d[n*LWS +: LWS] = w_src_lo[2*n*LWS +: LWS]
                                      + w_src_lo[(2*n+1)*LWS +: LWS];
            assign or_d[n*APX_BITS +: APX_BITS] = w_src_or[2*n*APX_BITS +: APX_BITS]
                                                | w_src_or[(2*n+1)*APX_BITS +: APX_BITS];
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lo_q <= '0;
               or_q <= '0;
            end else if (vld_q[k-1]) begin
               lo_q <= lo_d;
               or_q <= or_d;
            end
         end
      end

      logic [SW-1:0] w_exact;
      logic [SW-1:0] w_apx;
      assign w_exact = (SW'(w_up) << APX_BITS) + SW'(g_lo_lvl[L].lo_q);
      assign w_apx   = {w_up, g_lo_lvl[L].or_q};
      assign summ    = apx_q[L] ? w_apx : w_exact;
   end else begin : g_no_low
      assign summ = SW'(w_up);
   end

   assign out_valid = vld_q[L];
   assign out_apx   = apx_q[L];
endmodule
`default_nettype wire

// File: tb/tb_amoa_param_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_amoa_param_pipe                                                         |
// | Table-driven bench for the default build plus three parameter variants.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_amoa_param_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic v0, a0, ov0, oa0;  logic [63:0]  x0; logic [10:0] s0;
   logic v1, a1, ov1, oa1;  logic [29:0]  x1; logic [8:0]  s1;
   logic v2, a2, ov2, oa2;  logic [191:0] x2; logic [15:0] s2;
   logic v3, a3, ov3, oa3;  logic [7:0]   x3; logic [4:0]  s3;

   amoa_param_pipe u_d0 (.clk(clk), .rst(rst), .in_valid(v0), .apx_en(a0), .x_flat(x0),
                         .summ(s0), .out_valid(ov0), .out_apx(oa0));
   amoa_param_pipe #(.N_OPS(5), .W(6), .APX_BITS(0)) u_d1 (.clk(clk), .rst(rst),
      .in_valid(v1), .apx_en(a1), .x_flat(x1), .summ(s1), .out_valid(ov1), .out_apx(oa1));
   amoa_param_pipe #(.N_OPS(16), .W(12), .APX_BITS(3)) u_d2 (.clk(clk), .rst(rst),
      .in_valid(v2), .apx_en(a2), .x_flat(x2), .summ(s2), .out_valid(ov2), .out_apx(oa2));
   amoa_param_pipe #(.N_OPS(2), .W(4), .APX_BITS(1)) u_d3 (.clk(clk), .rst(rst),
      .in_valid(v3), .apx_en(a3), .x_flat(x3), .summ(s3), .out_valid(ov3), .out_apx(oa3));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        vld;
      logic        apx;
      logic [63:0] x;
      logic [10:0] exp;
   } vec_t;
   vec_t tbl[64];
   int   ntbl = 0;

   task automatic add(input logic v, input logic a, input logic [63:0] x, input int e);
      tbl[ntbl] = '{v, a, x, 11'(e)};
      ntbl++;
   endtask

   function automatic logic [63:0] mk(input int c);
      int b[8];
      logic [63:0] r;
      b = '{1, 2, 3, 4, 4, 3, 2, 1};
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(c + b[i]);
      return r;
   endfunction

   function automatic logic [191:0] rnd192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic longint model(input int n, input int w, input int ab,
                                    input logic [191:0] x, input logic apx);
      longint s = 0, up = 0, orv = 0, op;
      for (int i = 0; i < n; i++) begin
         op  = longint'((x >> (i*w)) & ((192'd1 << w) - 1));
         s  += op;
         up += op >> ab;
         orv |= op & ((64'd1 << ab) - 1);
      end
      return (apx && ab > 0) ? ((up << ab) | orv) : s;
   endfunction

   localparam int NS = 40;
   logic   hv[3][64];
   logic   ha[3][64];
   longint he[3][64];
   longint es[3];
   logic   ea[3];
   int     lat[3] = '{4, 5, 2};
   int     nn[3]  = '{5, 16, 2};
   int     ww[3]  = '{6, 12, 4};
   int     aa[3]  = '{0, 3, 1};

   initial begin
      logic [10:0] exp_s;
      logic        exp_a;
      logic        ap;
      logic [191:0] xr;
      longint       act_s;
      logic         act_v, act_a;

      // Directed table
      add(1, 0, mk(0), 20);
      add(1, 1, mk(0), 11);
      add(1, 0, {64{1'b1}}, 2040);
      add(1, 1, {64{1'b1}}, 2019);
      add(1, 0, 64'd0, 0);
      add(1, 1, 64'd0, 0);
      for (int c = 0; c < 6; c++) add(1, 0, mk(c), 8*c + 20);
      add(1, 1, mk(1), 19);
      ap = 1'b0;
      for (int p = 0; p < 9; p++) begin
         if (p % 3 == 2) add(0, 1'($urandom), {$urandom, $urandom}, 0);
         else begin
            add(1, ap, mk(0), ap ? 11 : 20);
            ap = ~ap;
         end
      end

      v1 = 0; a1 = 0; x1 = '0;
      v2 = 0; a2 = 0; x2 = '0;
      v3 = 0; a3 = 0; x3 = '0;

      // Reset held with valid data present
      rst = 1'b1; v0 = 1'b1; a0 = 1'b1; x0 = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rst%0d_summ", i), s0, 0);
         chk($sformatf("rst%0d_valid", i), ov0, 0);
         chk($sformatf("rst%0d_apx", i), oa0, 0);
         x0 = {$urandom, $urandom};
      end
      rst = 1'b0;

      exp_s = '0; exp_a = 1'b0;
      for (int t = 0; t < ntbl + 3; t++) begin
         if (t < ntbl) begin
            v0 = tbl[t].vld; a0 = tbl[t].apx; x0 = tbl[t].x;
         end else begin
            v0 = 1'b0;
         end
         @(posedge clk); #1;
         if (t < 3) begin
            chk($sformatf("lat_pre%0d_valid", t), ov0, 0);
         end else begin
            if (tbl[t-3].vld) begin
               exp_s = tbl[t-3].exp;
               exp_a = tbl[t-3].apx;
            end
            chk($sformatf("tbl%0d_valid", t-3), ov0, tbl[t-3].vld);
            chk($sformatf("tbl%0d_summ", t-3), s0, exp_s);
            chk($sformatf("tbl%0d_apx", t-3), oa0, exp_a);
         end
      end

      // Reset with three samples in flight
      for (int i = 0; i < 3; i++) begin
         v0 = 1'b1; a0 = 1'b0; x0 = mk(2 + i);
         @(posedge clk); #1;
      end
      v0 = 1'b0; rst = 1'b1;
      #1;
      chk("midrst_async_valid", ov0, 0);
      chk("midrst_async_summ", s0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst%0d_valid", i), ov0, 0);
         chk($sformatf("midrst%0d_summ", i), s0, 0);
      end
      v0 = 1'b1; a0 = 1'b0; x0 = mk(0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         v0 = 1'b0;
         chk($sformatf("postrst%0d_valid", i), ov0, (i == 3) ? 1 : 0);
      end
      chk("postrst_summ", s0, 20);

      // Parameter variants against the reference model
      for (int k = 0; k < 3; k++) begin
         es[k] = 0; ea[k] = 1'b0;
      end
      for (int t = 0; t < NS + 6; t++) begin
         for (int k = 0; k < 3; k++) begin
            xr = rnd192();
            hv[k][t] = (t < NS) ? ($urandom_range(0, 3) != 0) : 1'b0;
            ha[k][t] = 1'($urandom);
            if (k == 0 && t == 0) begin
               xr = {192{1'b1}}; hv[k][t] = 1'b1; ha[k][t] = 1'b0;
            end
            he[k][t] = model(nn[k], ww[k], aa[k], xr, ha[k][t]);
            case (k)
               0: begin v1 = hv[k][t]; a1 = ha[k][t]; x1 = xr[29:0];  end
               1: begin v2 = hv[k][t]; a2 = ha[k][t]; x2 = xr;        end
               default: begin v3 = hv[k][t]; a3 = ha[k][t]; x3 = xr[7:0]; end
            endcase
         end
         @(posedge clk); #1;
         if (t == 3) chk("n5_all63_summ", s1, 315);
         for (int k = 0; k < 3; k++) begin
            int j;
            j = t - lat[k] + 1;
            case (k)
               0: begin act_v = ov1; act_a = oa1; act_s = s1; end
               1: begin act_v = ov2; act_a = oa2; act_s = s2; end
               default: begin act_v = ov3; act_a = oa3; act_s = s3; end
            endcase
            if (j >= 0) begin
               if (hv[k][j]) begin
                  es[k] = he[k][j];
                  ea[k] = ha[k][j];
               end
               chk($sformatf("sw%0d_%0d_valid", k, j), act_v, hv[k][j]);
               chk($sformatf("sw%0d_%0d_summ", k, j), act_s, es[k]);
               chk($sformatf("sw%0d_%0d_apx", k, j), act_a, ea[k]);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/amoa_param_pipe.md
Name: amoa_param_pipe

Overview:
- Parametrised, pipelined approximate multi-operand adder. Successor to the fixed 8-operand x 8-bit radix-8 approximate adder.
- Sums N_OPS unsigned operands of W bits each through a registered binary adder tree.
- A per-sample run-time mode selects either the exact sum or a lower-part-OR approximation on the APX_BITS least significant columns.
- A valid bit travels with each sample. Used as the datapath reduction stage feeding the accumulator/MAC blocks.

Parameters:
- N_OPS, 8, number of operands; integer >= 2; need not be a power of two.
- W, 8, operand width in bits; >= 2.
- APX_BITS, 2, number of low columns approximated in approximate mode; 0 <= APX_BITS < W.
- SW, W+$clog2(N_OPS), sum width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies x_flat and apx_en this cycle.
- apx_en  in  1  1 = approximate mode, 0 = exact mode; sampled together with the data.
- x_flat  in  N_OPS*W  operands; operand i is x_flat[i*W +: W].
- summ  out  SW  sum result.
- out_valid  out  1  qualifies summ.
- out_apx  out  1  mode that produced the current summ.

Behaviour:
- Reset: while rst=1, every pipeline register, summ, out_valid and out_apx is 0. Assertion at any time, including mid-stream, discards all in-flight samples. The first in_valid after rst falls is processed normally.
- Stage 0 (input register):
  - Captures x_flat, apx_en and in_valid on every clk edge.
  - Data registers load only when in_valid=1.
  - The valid register always loads in_valid.
- Tree:
  - L = $clog2(N_OPS) adder levels, each followed by a register.
  - Level k pairs adjacent partial sums. An odd leftover passes through unchanged, still registered.
  - When N_OPS is not a power of two, missing leaves are zero.
  - Partial sums widen by 1 bit per level, so no overflow is possible.
- Latency: fixed LAT = L+1 cycles from the in_valid edge to out_valid. N_OPS=8 gives LAT=4.
  - Throughput is one sample per cycle. There is no backpressure.
  - Bubbles (in_valid=0) propagate as out_valid=0.
  - While out_valid=0, summ and out_apx hold their previous value.
- Exact mode (apx_en=0): summ = sum of all operands, full SW bits.
- Approximate mode (apx_en=1, APX_BITS>0):
  - summ[APX_BITS-1:0] = bitwise OR over all operands of x_i[APX_BITS-1:0].
  - summ[SW-1:APX_BITS] = exact sum of the x_i[W-1:APX_BITS].
  - No carry crosses from the low part into the upper part.
  - Approximate mode with APX_BITS=0 equals exact mode.
- Mode per sample:
  - apx_en is pipelined alongside the data.
  - Consecutive samples may alternate modes with no bubble. Each result reflects its own sample's mode.
- Implementation structure:
  - Low and upper fields are kept as separate tree lanes.
  - The low lane carries both the OR-reduction and the exact low sum.
  - Final-stage mux: exact = (upper << APX_BITS) + low_sum; approx = {upper, low_or}.
- Boundaries:
  - All operands at 2^W-1 in exact mode gives summ = N_OPS*(2^W-1), which fits SW bits.
  - All-zero operands give summ=0 in both modes.
  - Simultaneous in_valid and rst: reset wins; the sample is dropped.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 and random data -> summ=0, out_valid=0, out_apx=0 throughout. First out_valid appears exactly 4 cycles after the first post-reset in_valid.
- Exact, default parameters: operands {1,2,3,4,4,3,2,1}, apx_en=0 -> summ=20, out_valid=1 at cycle +4. Then a counter-driven stream, operands c+{1,2,3,4,4,3,2,1} -> summ=8c+20 every cycle.
- Approximate, APX_BITS=2: the same {1,2,3,4,4,3,2,1}, apx_en=1 -> summ=11 (upper 2<<2=8, low OR=3), out_apx=1.
- Saturation corners: all operands 255 -> exact summ=2040; approximate summ=2019. All zeros -> 0 in both modes.
- Mode interleave and bubbles:
  - Stimulus: alternate apx_en 0/1 on the {1,2,3,4,4,3,2,1} vector, with in_valid=0 every 3rd cycle.
  - Required response: outputs alternate 20/11 with matching out_apx; gaps appear at the same positions, delayed 4 cycles; summ holds its value during gaps.
- Reset mid-stream plus parameter sweep:
  - Assert rst for 1 cycle with 3 samples in flight -> none of them emerges.
  - Re-run random self-checking compared against a reference model for (N_OPS,W,APX_BITS) = (5,6,0), (16,12,3), (2,4,1).
  - For N_OPS=5: LAT=4, and all operands 63 gives summ=315.
